// File: rtl/pin_route_pkg.sv
// Shared types and helpers for the board pin-route break-before-make sequencer.
// Holds the FSM state encoding, the pmodD[3:2] owner encoding, and route bit indices.
// Also provides the owner decode and the saturating counter increment used by the top.
package pin_route_pkg;

  // Sequencer states: idle, force tristate, switch selects, hold tristate.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    APPLY   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Owner of the contended pmodD[3:2] pads.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_PLUG   = 2'd1,
    OWN_P31_30 = 2'd2,
    OWN_P27_26 = 2'd3
  } owner_t;

  // Route bit positions in req_route / route_sel / route_quiesce.
  localparam int ROUTE_PS2   = 0;
  localparam int ROUTE_VGA   = 1;
  localparam int ROUTE_AUDIO = 2;
  localparam int ROUTE_PLUG  = 3;

  // Transaction counter width; it sticks at its maximum instead of wrapping.
  localparam int CHG_CNT_W = 8;

  // Saturating increment for the completed-transaction counter.
  function automatic logic [CHG_CNT_W-1:0] sat_inc(input logic [CHG_CNT_W-1:0] v);
    logic [CHG_CNT_W-1:0] r;
    r = (v == {CHG_CNT_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

  // Decode who may drive pmodD[3:2]. Any tristate on the PS2 or Plug routes
  // means both candidate drivers may be mid-switch, so nobody owns the pads.
  function automatic owner_t owner_of(input logic q_ps2,
                                      input logic q_plug,
                                      input logic sel_ps2,
                                      input logic sel_plug);
    owner_t o;
    if (q_ps2 || q_plug) begin
      o = OWN_NONE;
    end else if (sel_plug) begin
      o = OWN_PLUG;
    end else if (sel_ps2) begin
      o = OWN_P31_30;
    end else begin
      o = OWN_P27_26;
    end
    return o;
  endfunction

endpackage

// File: rtl/pin_route_ctrl_guard_timer.sv
// Guard interval timer: loadable down-counter with a zero flag.
// Latency: load/decrement take effect on the next clock; o_zero is decoded from the register.
// No backpressure: load wins over decrement, decrement stops at zero.
module guard_timer #(
  parameter int GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GUARD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: reload to GUARD_CYCLES-1 or count down toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pin_route_ctrl.sv
// Break-before-make sequencer for the Propeller pin multiplexers plus pmodD[3:2] owner arbitration.
// Latency: quiesce at t+1, route_sel at t+GUARD_CYCLES+2, idle again at t+2*GUARD_CYCLES+2.
// No backpressure: requests are level-sampled; changes during RELEASE wait for the next IDLE.
module pin_route_ctrl
  import pin_route_pkg::*;
#(
  parameter int NUM_ROUTES   = 4,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_ROUTES-1:0] req_route,
  output logic [NUM_ROUTES-1:0] route_sel,
  output logic [NUM_ROUTES-1:0] route_quiesce,
  output logic [1:0]            pmodd_owner,
  output logic                  changing,
  output logic [7:0]            change_count
);

  // Registered state.
  state_t                r_state;
  logic [NUM_ROUTES-1:0] r_pending;
  logic [NUM_ROUTES-1:0] r_quiesce;
  logic [NUM_ROUTES-1:0] r_sel;
  logic [CHG_CNT_W-1:0]  r_chg_cnt;
  owner_t                r_owner;

  // Next-state values from the FSM decode.
  state_t                w_state_nxt;
  logic [NUM_ROUTES-1:0] w_pending_nxt;
  logic [NUM_ROUTES-1:0] w_quiesce_nxt;
  logic [NUM_ROUTES-1:0] w_sel_nxt;
  logic [CHG_CNT_W-1:0]  w_chg_cnt_nxt;
  owner_t                w_owner_nxt;

  // Guard timer controls.
  logic w_tmr_load;
  logic w_tmr_dec;
  logic w_tmr_zero;

  // Request differs from what is currently driven / currently queued.
  logic [NUM_ROUTES-1:0] w_req_diff;
  logic                  w_req_new;
  logic                  w_req_moved;

  assign w_req_diff  = req_route ^ r_sel;
  assign w_req_new   = (w_req_diff != '0);
  assign w_req_moved = (req_route != r_pending);

  guard_timer #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_guard_timer (
    .clk    (clock),
    .rst    (reset),
    .i_load (w_tmr_load),
    .i_dec  (w_tmr_dec),
    .o_zero (w_tmr_zero)
  );

  // FSM next-state and datapath decode; everything holds unless a state acts.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_quiesce_nxt = r_quiesce;
    w_sel_nxt     = r_sel;
    w_chg_cnt_nxt = r_chg_cnt;
    w_tmr_load    = 1'b0;
    w_tmr_dec     = 1'b0;

    case (r_state)
      IDLE: begin
        // Only the routes actually changing get forced to tristate.
        if (w_req_new) begin
          w_pending_nxt = req_route;
          w_quiesce_nxt = w_req_diff;
          w_tmr_load    = 1'b1;
          w_state_nxt   = QUIESCE;
        end
      end

      QUIESCE: begin
        // A moving request restarts the guard; quiesce bits only accumulate
        // so a route already tristated is never briefly re-enabled.
        if (w_req_moved) begin
          w_pending_nxt = req_route;
          w_quiesce_nxt = r_quiesce | w_req_diff;
          w_tmr_load    = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_nxt = APPLY;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      APPLY: begin
        // Switch the mux selects while every affected pad is still tristated.
        w_sel_nxt   = r_pending;
        w_tmr_load  = 1'b1;
        w_state_nxt = RELEASE;
      end

      RELEASE: begin
        // Hold tristate after the switch; requests wait for IDLE.
        if (w_tmr_zero) begin
          w_quiesce_nxt = '0;
          w_chg_cnt_nxt = sat_inc(r_chg_cnt);
          w_state_nxt   = IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Owner follows the registered selects/quiesce one cycle later, so NONE is
  // already in place before route_sel moves and persists one cycle past release.
  always_comb begin
    w_owner_nxt = owner_of(r_quiesce[ROUTE_PS2], r_quiesce[ROUTE_PLUG],
                           r_sel[ROUTE_PS2],     r_sel[ROUTE_PLUG]);
  end

  // State and output registers; reset drops any half-finished transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_quiesce <= '0;
      r_sel     <= '0;
      r_chg_cnt <= '0;
      r_owner   <= OWN_P27_26;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_quiesce <= w_quiesce_nxt;
      r_sel     <= w_sel_nxt;
      r_chg_cnt <= w_chg_cnt_nxt;
      r_owner   <= w_owner_nxt;
    end
  end

  assign route_sel     = r_sel;
  assign route_quiesce = r_quiesce;
  assign pmodd_owner   = r_owner;
  assign changing      = (r_state != IDLE);
  assign change_count  = r_chg_cnt;

endmodule

// File: doc/pin_route_ctrl.md
Name: pin_route_ctrl

Overview:
- Break-before-make sequencer for the board-level Propeller pin multiplexers: PS2/pmodD, VGA/pmodC, audio/pmodB and USB-UART/Prop Plug.
- Takes the debounced mode switches as routing requests. Before applying a new routing it forces tristate on every affected route for a guard interval, then holds tristate for a further guard interval afterwards.
- Also arbitrates ownership of the contended pmodD[3:2] pads.
- Sits between the switch debouncer and the top-level pin multiplexers; runs on slow_clk.

Parameters:
- NUM_ROUTES, 4, number of independently switched routes (bit i = one mode switch).
- GUARD_CYCLES, 16, tristate guard length in clock cycles; legal range 1..255.
- CNT_W, $clog2(GUARD_CYCLES+1), guard counter width (derived; do not override).

Ports:
- clock  input  1  slow system clock.
- reset  input  1  asynchronous, active-high reset.
- req_route  input  NUM_ROUTES  requested routing (debounced switches); bit0=PS2 swap, bit1=VGA-to-pmodC, bit2=audio-to-pmodB, bit3=Prop Plug.
- route_sel  output  NUM_ROUTES  applied routing, registered; drives the mux selects.
- route_quiesce  output  NUM_ROUTES  per-route force-tristate, registered; the mux must tristate every pad of route i while bit i=1.
- pmodd_owner  output  2  owner of pmodD[3:2]: 0 NONE, 1 PLUG, 2 P31_30, 3 P27_26.
- changing  output  1  high whenever FSM is not IDLE.
- change_count  output  8  completed transactions, saturating at 255.

Behaviour:
- Reset (async, active-high) sets: route_sel=0, route_quiesce=0, pending=0, counter=0, state=IDLE, change_count=0, changing=0, pmodd_owner=P27_26.
- States: IDLE, QUIESCE, APPLY, RELEASE.
- IDLE:
  - If req_route != route_sel, register pending=req_route and route_quiesce=req_route^route_sel, load counter=GUARD_CYCLES-1, go to QUIESCE.
  - Otherwise hold all outputs.
- QUIESCE:
  - If counter==0, go to APPLY; otherwise decrement.
  - Occupies exactly GUARD_CYCLES cycles when no retrigger occurs.
  - Retrigger: if req_route != pending in any QUIESCE cycle, register pending=req_route, route_quiesce |= req_route^route_sel, reload counter=GUARD_CYCLES-1 and stay in QUIESCE. Quiesce bits never drop during QUIESCE.
  - If req_route returns to equal route_sel, the transaction still completes, with a null APPLY.
- APPLY (one cycle): register route_sel=pending, load counter=GUARD_CYCLES-1, go to RELEASE.
- RELEASE:
  - Count down GUARD_CYCLES cycles, ignoring req_route.
  - On the counter==0 cycle: route_quiesce<=0, change_count<=sat(change_count+1), state<=IDLE.
  - Any request pending at IDLE starts a new transaction in the following cycle.
- Latency: req_route changes at cycle t (state IDLE, no retrigger):
  - route_quiesce valid at t+1;
  - route_sel updated at t+GUARD_CYCLES+2;
  - route_quiesce clears and state is IDLE at t+2*GUARD_CYCLES+2.
- pmodd_owner (registered, next-state function of route_sel and route_quiesce):
  - NONE if route_quiesce[0] or route_quiesce[3] is set;
  - else PLUG if route_sel[3];
  - else P31_30 if route_sel[0];
  - else P27_26.
  - Exactly one owner at any time; NONE always covers the cycle in which route_sel[0] or route_sel[3] changes.
- changing = (state != IDLE), decoded from the state register; no combinational path from req_route.
- Reset mid-transaction returns immediately to the reset values; no partial route_sel is retained.
- Changes to untouched route bits never assert their quiesce bits.

Decomposition:
- pin_route_pkg holds:
  - typedef enum state_t {IDLE, QUIESCE, APPLY, RELEASE};
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_PLUG, OWN_P31_30, OWN_P27_26};
  - localparams ROUTE_PS2=0, ROUTE_VGA=1, ROUTE_AUDIO=2, ROUTE_PLUG=3.
- One sub-module, guard_timer: load/decrement counter with a zero flag, parameterised by GUARD_CYCLES.

Test Plan:
- Reset, then req_route=0000 held for 50 cycles → route_sel=0000, route_quiesce=0000, changing=0, pmodd_owner=3, change_count=0.
- GUARD_CYCLES=4; req_route 0000→0010 at cycle t → route_quiesce=0010 at t+1; route_sel=0010 at t+6; route_quiesce=0000 and changing=0 at t+10; change_count=1; other quiesce bits stay 0.
- req_route 0000→1000 → pmodd_owner=0 from t+2 until route_quiesce clears, then 1; never 2 or 3 while quiesce[3]=1.
- GUARD_CYCLES=4; req 0000→0001 at t, then 0001→0101 at t+2 → route_quiesce=0101 from t+3; counter reloads; route_sel=0101 at t+8; single transaction, change_count=1.
- req change during RELEASE (0010→0011 at t+7, G=4) → ignored until IDLE at t+10; second transaction starts at t+11; change_count=2 at completion.
- reset asserted at t+5 mid-QUIESCE → asynchronously route_sel=0, route_quiesce=0, changing=0, change_count=0; 256 transactions → change_count=255 saturated.
